// File: rtl/sh_ddr_axi_slave_model_if.sv
// AXI4 write/read channel bundle between a DDR client (master) and the DDR slave model.
// Every channel is valid/ready: a transfer happens on a rising clk_core edge where both are 1,
// and the source holds its payload stable while valid is 1 and ready is 0.
interface sh_ddr_axi_slave_model_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 64
);
    logic [ID_WIDTH-1:0]     cl_sh_ddr_awid;
    logic [ADDR_WIDTH-1:0]   cl_sh_ddr_awaddr;
    logic [7:0]              cl_sh_ddr_awlen;
    logic [1:0]              cl_sh_ddr_awburst;
    logic                    cl_sh_ddr_awvalid;
    logic                    sh_cl_ddr_awready;

    logic [DATA_WIDTH-1:0]   cl_sh_ddr_wdata;
    logic [DATA_WIDTH/8-1:0] cl_sh_ddr_wstrb;
    logic                    cl_sh_ddr_wlast;
    logic                    cl_sh_ddr_wvalid;
    logic                    sh_cl_ddr_wready;

    logic [ID_WIDTH-1:0]     sh_cl_ddr_bid;
    logic [1:0]              sh_cl_ddr_bresp;
    logic                    sh_cl_ddr_bvalid;
    logic                    cl_sh_ddr_bready;

    logic [ID_WIDTH-1:0]     cl_sh_ddr_arid;
    logic [ADDR_WIDTH-1:0]   cl_sh_ddr_araddr;
    logic [7:0]              cl_sh_ddr_arlen;
    logic [1:0]              cl_sh_ddr_arburst;
    logic                    cl_sh_ddr_arvalid;
    logic                    sh_cl_ddr_arready;

    logic [ID_WIDTH-1:0]     sh_cl_ddr_rid;
    logic [DATA_WIDTH-1:0]   sh_cl_ddr_rdata;
    logic [1:0]              sh_cl_ddr_rresp;
    logic                    sh_cl_ddr_rlast;
    logic                    sh_cl_ddr_rvalid;
    logic                    cl_sh_ddr_rready;

    modport master (
        output cl_sh_ddr_awid, cl_sh_ddr_awaddr, cl_sh_ddr_awlen, cl_sh_ddr_awburst, cl_sh_ddr_awvalid,
        input  sh_cl_ddr_awready,
        output cl_sh_ddr_wdata, cl_sh_ddr_wstrb, cl_sh_ddr_wlast, cl_sh_ddr_wvalid,
        input  sh_cl_ddr_wready,
        input  sh_cl_ddr_bid, sh_cl_ddr_bresp, sh_cl_ddr_bvalid,
        output cl_sh_ddr_bready,
        output cl_sh_ddr_arid, cl_sh_ddr_araddr, cl_sh_ddr_arlen, cl_sh_ddr_arburst, cl_sh_ddr_arvalid,
        input  sh_cl_ddr_arready,
        input  sh_cl_ddr_rid, sh_cl_ddr_rdata, sh_cl_ddr_rresp, sh_cl_ddr_rlast, sh_cl_ddr_rvalid,
        output cl_sh_ddr_rready
    );

    modport slave (
        input  cl_sh_ddr_awid, cl_sh_ddr_awaddr, cl_sh_ddr_awlen, cl_sh_ddr_awburst, cl_sh_ddr_awvalid,
        output sh_cl_ddr_awready,
        input  cl_sh_ddr_wdata, cl_sh_ddr_wstrb, cl_sh_ddr_wlast, cl_sh_ddr_wvalid,
        output sh_cl_ddr_wready,
        output sh_cl_ddr_bid, sh_cl_ddr_bresp, sh_cl_ddr_bvalid,
        input  cl_sh_ddr_bready,
        input  cl_sh_ddr_arid, cl_sh_ddr_araddr, cl_sh_ddr_arlen, cl_sh_ddr_arburst, cl_sh_ddr_arvalid,
        output sh_cl_ddr_arready,
        output sh_cl_ddr_rid, sh_cl_ddr_rdata, sh_cl_ddr_rresp, sh_cl_ddr_rlast, sh_cl_ddr_rvalid,
        input  cl_sh_ddr_rready
    );
endinterface

// File: rtl/sh_ddr_axi_slave_model.sv
// Single-channel AXI4 slave memory model: queued AW/AR/B, FIXED/INCR/WRAP bursts,
// programmable read latency, SLVERR address window and a sticky wlast-mismatch flag.
module sh_ddr_axi_slave_model #(
    parameter int                    DATA_WIDTH     = 512,
    parameter int                    ID_WIDTH       = 16,
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    MEM_WORDS_LOG2 = 12,
    parameter int                    RD_LATENCY     = 4,
    parameter int                    AQ_DEPTH       = 4,
    parameter bit                    ERR_EN         = 1'b0,
    parameter logic [ADDR_WIDTH-1:0] ERR_ADDR_LO    = 'h400,
    parameter logic [ADDR_WIDTH-1:0] ERR_ADDR_HI    = 'h410
) (
    input  logic                     clk_core,
    input  logic                     rst_core,
    sh_ddr_axi_slave_model_if.slave  axi,
    output logic                     protocol_err,
    output logic [1:0]               dbg_rd_state
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int BYTE_SH   = $clog2(STRB_W);
    localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
    localparam int QW        = $clog2(AQ_DEPTH);
    localparam int LAT_W     = $clog2(RD_LATENCY + 1);
    localparam logic [QW:0] Q_FULL = (QW+1)'(AQ_DEPTH);

    typedef logic [MEM_WORDS_LOG2-1:0] word_t;
    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [1:0]            burst;
    } areq_t;
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          resp;
    } bent_t;
    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_WAIT = 2'd1, RD_BURST = 2'd2} rd_state_e;

    // WRAP stays inside the (len+1)-word aligned block; illegal WRAP lengths fall back to INCR.
    function automatic word_t beat_word(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                        input logic [1:0] burst, input logic [7:0] beat);
        word_t start, mask, inc;
        start = addr[BYTE_SH +: MEM_WORDS_LOG2];
        inc   = start + word_t'(beat);
        mask  = word_t'(len);
        case (burst)
            2'b00:   beat_word = start;
            2'b10:   beat_word = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) ?
                                 ((start & ~mask) | (inc & mask)) : inc;
            default: beat_word = inc;
        endcase
    endfunction

    function automatic logic [1:0] err_resp(input logic [ADDR_WIDTH-1:0] addr);
        err_resp = (ERR_EN && addr >= ERR_ADDR_LO && addr <= ERR_ADDR_HI) ? 2'b10 : 2'b00;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    areq_t aw_buf [AQ_DEPTH];
    areq_t ar_buf [AQ_DEPTH];
    bent_t b_buf  [AQ_DEPTH];

    logic [QW-1:0] aw_wp_q, aw_wp_d, aw_rp_q, aw_rp_d, ar_wp_q, ar_wp_d, ar_rp_q, ar_rp_d;
    logic [QW-1:0] b_wp_q, b_wp_d, b_rp_q, b_rp_d;
    logic [QW:0]   aw_cnt_q, aw_cnt_d, ar_cnt_q, ar_cnt_d, b_cnt_q, b_cnt_d;
    logic          awready_q, awready_d, arready_q, arready_d, protocol_err_q, protocol_err_d;
    logic [7:0]    w_beat_q, w_beat_d, rd_beat_q, rd_beat_d;
    logic [LAT_W-1:0] rd_lat_q, rd_lat_d;
    logic [1:0]    rd_resp_q, rd_resp_d;
    areq_t         rd_req_q, rd_req_d;
    rd_state_e     rd_state_q, rd_state_d;

    areq_t aw_in, ar_in, aw_head;
    bent_t b_head;
    logic  aw_push, aw_pop, ar_push, ar_pop, b_push, b_pop;
    logic  wready, w_fire, w_final, bvalid, rvalid, r_last;
    word_t w_word, rd_word;

    assign aw_in   = {axi.cl_sh_ddr_awid, axi.cl_sh_ddr_awaddr, axi.cl_sh_ddr_awlen, axi.cl_sh_ddr_awburst};
    assign ar_in   = {axi.cl_sh_ddr_arid, axi.cl_sh_ddr_araddr, axi.cl_sh_ddr_arlen, axi.cl_sh_ddr_arburst};
    assign aw_head = aw_buf[aw_rp_q];
    assign b_head  = b_buf[b_rp_q];

    assign aw_push = axi.cl_sh_ddr_awvalid && awready_q;
    assign ar_push = axi.cl_sh_ddr_arvalid && arready_q;
    assign wready  = (aw_cnt_q != '0) && (b_cnt_q != Q_FULL);
    assign w_fire  = axi.cl_sh_ddr_wvalid && wready;
    assign w_final = (w_beat_q == aw_head.len);
    assign w_word  = beat_word(aw_head.addr, aw_head.len, aw_head.burst, w_beat_q);
    assign aw_pop  = w_fire && w_final;
    assign b_push  = aw_pop;
    assign bvalid  = (b_cnt_q != '0);
    assign b_pop   = bvalid && axi.cl_sh_ddr_bready;
    assign rvalid  = (rd_state_q == RD_BURST);
    assign r_last  = (rd_beat_q == rd_req_q.len);
    assign rd_word = beat_word(rd_req_q.addr, rd_req_q.len, rd_req_q.burst, rd_beat_q);

    always_comb begin
        aw_wp_d = aw_wp_q; aw_rp_d = aw_rp_q; aw_cnt_d = aw_cnt_q;
        ar_wp_d = ar_wp_q; ar_rp_d = ar_rp_q; ar_cnt_d = ar_cnt_q;
        b_wp_d  = b_wp_q;  b_rp_d  = b_rp_q;  b_cnt_d  = b_cnt_q;
        if (aw_push) aw_wp_d = aw_wp_q + 1'b1;
        if (aw_pop)  aw_rp_d = aw_rp_q + 1'b1;
        if (aw_push && !aw_pop) aw_cnt_d = aw_cnt_q + 1'b1;
        if (!aw_push && aw_pop) aw_cnt_d = aw_cnt_q - 1'b1;
        if (ar_push) ar_wp_d = ar_wp_q + 1'b1;
        if (ar_pop)  ar_rp_d = ar_rp_q + 1'b1;
        if (ar_push && !ar_pop) ar_cnt_d = ar_cnt_q + 1'b1;
        if (!ar_push && ar_pop) ar_cnt_d = ar_cnt_q - 1'b1;
        if (b_push) b_wp_d = b_wp_q + 1'b1;
        if (b_pop)  b_rp_d = b_rp_q + 1'b1;
        if (b_push && !b_pop) b_cnt_d = b_cnt_q + 1'b1;
        if (!b_push && b_pop) b_cnt_d = b_cnt_q - 1'b1;
        awready_d = (aw_cnt_d != Q_FULL);
        arready_d = (ar_cnt_d != Q_FULL);
        w_beat_d  = w_beat_q;
        if (w_fire) w_beat_d = w_final ? 8'd0 : w_beat_q + 8'd1;
        // The beat counter decides the burst end; wlast only feeds the sticky flag.
        protocol_err_d = protocol_err_q || (w_fire && (axi.cl_sh_ddr_wlast != w_final));
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_req_d   = rd_req_q;
        rd_resp_d  = rd_resp_q;
        rd_lat_d   = rd_lat_q;
        rd_beat_d  = rd_beat_q;
        ar_pop     = 1'b0;
        case (rd_state_q)
            RD_IDLE: if (ar_cnt_q != '0) begin
                ar_pop     = 1'b1;
                rd_req_d   = ar_buf[ar_rp_q];
                rd_resp_d  = err_resp(ar_buf[ar_rp_q].addr);
                rd_lat_d   = LAT_W'(RD_LATENCY - 1);
                rd_beat_d  = 8'd0;
                rd_state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_lat_q == '0) rd_state_d = RD_BURST;
                else                rd_lat_d   = rd_lat_q - 1'b1;
            end
            RD_BURST: if (axi.cl_sh_ddr_rready) begin
                if (r_last) rd_state_d = RD_IDLE;
                else        rd_beat_d  = rd_beat_q + 8'd1;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            aw_wp_q <= '0; aw_rp_q <= '0; aw_cnt_q <= '0;
            ar_wp_q <= '0; ar_rp_q <= '0; ar_cnt_q <= '0;
            b_wp_q  <= '0; b_rp_q  <= '0; b_cnt_q  <= '0;
            awready_q <= 1'b0; arready_q <= 1'b0; protocol_err_q <= 1'b0;
            w_beat_q <= '0; rd_beat_q <= '0; rd_lat_q <= '0; rd_resp_q <= '0;
            rd_req_q <= '0; rd_state_q <= RD_IDLE;
        end else begin
            aw_wp_q <= aw_wp_d; aw_rp_q <= aw_rp_d; aw_cnt_q <= aw_cnt_d;
            ar_wp_q <= ar_wp_d; ar_rp_q <= ar_rp_d; ar_cnt_q <= ar_cnt_d;
            b_wp_q  <= b_wp_d;  b_rp_q  <= b_rp_d;  b_cnt_q  <= b_cnt_d;
            awready_q <= awready_d; arready_q <= arready_d; protocol_err_q <= protocol_err_d;
            w_beat_q <= w_beat_d; rd_beat_q <= rd_beat_d; rd_lat_q <= rd_lat_d; rd_resp_q <= rd_resp_d;
            rd_req_q <= rd_req_d; rd_state_q <= rd_state_d;
        end
    end

    // Storage is deliberately not reset: memory survives rst_core, queue slots are gated by counts.
    always_ff @(posedge clk_core) begin
        if (aw_push) aw_buf[aw_wp_q] <= aw_in;
        if (ar_push) ar_buf[ar_wp_q] <= ar_in;
        if (b_push)  b_buf[b_wp_q]   <= '{id: aw_head.id, resp: err_resp(aw_head.addr)};
        if (w_fire) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi.cl_sh_ddr_wstrb[i]) mem[w_word][i*8 +: 8] <= axi.cl_sh_ddr_wdata[i*8 +: 8];
            end
        end
    end

    assign axi.sh_cl_ddr_awready = awready_q;
    assign axi.sh_cl_ddr_arready = arready_q;
    assign axi.sh_cl_ddr_wready  = wready;
    assign axi.sh_cl_ddr_bvalid  = bvalid;
    assign axi.sh_cl_ddr_bid     = bvalid ? b_head.id   : '0;
    assign axi.sh_cl_ddr_bresp   = bvalid ? b_head.resp : 2'b00;
    assign axi.sh_cl_ddr_rvalid  = rvalid;
    assign axi.sh_cl_ddr_rid     = rvalid ? rd_req_q.id : '0;
    assign axi.sh_cl_ddr_rresp   = rvalid ? rd_resp_q   : 2'b00;
    assign axi.sh_cl_ddr_rlast   = rvalid && r_last;
    assign axi.sh_cl_ddr_rdata   = rvalid ? mem[rd_word] : '0;
    assign protocol_err          = protocol_err_q;
    assign dbg_rd_state          = rd_state_q;
endmodule

// File: tb/tb_sh_ddr_axi_slave_model.sv
// Bench for sh_ddr_axi_slave_model: directed scenarios plus randomized bursts, scoreboarded
// against a byte-level reference memory and address arithmetic taken from the burst rules.
module tb_sh_ddr_axi_slave_model;
    localparam int DW = 512;
    localparam int RD_LAT = 4;

    typedef struct packed { logic [15:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [15:0] id; logic [1:0] resp; logic last; logic [DW-1:0] data; } r_exp_t;

    logic clk_core = 1'b0;
    logic rst_core = 1'b1;
    logic protocol_err;
    logic [1:0] dbg_rd_state;
    int checks = 0;
    int errors = 0;
    int bready_mode = 1;
    int rready_mode = 1;
    int aw_sent = 0;

    b_exp_t exp_b_q[$];
    r_exp_t exp_r_q[$];
    logic [DW-1:0] ref_mem [0:4095];
    logic [DW-1:0] wdat [0:15];
    logic [63:0]   wstb [0:15];

    sh_ddr_axi_slave_model_if #(.DATA_WIDTH(DW), .ID_WIDTH(16), .ADDR_WIDTH(64)) axi ();

    sh_ddr_axi_slave_model #(
        .DATA_WIDTH(DW), .ID_WIDTH(16), .ADDR_WIDTH(64), .MEM_WORDS_LOG2(12),
        .RD_LATENCY(RD_LAT), .AQ_DEPTH(4), .ERR_EN(1'b1), .ERR_ADDR_LO(64'h400), .ERR_ADDR_HI(64'h410)
    ) dut (
        .clk_core(clk_core), .rst_core(rst_core), .axi(axi),
        .protocol_err(protocol_err), .dbg_rd_state(dbg_rd_state)
    );

    always #5 clk_core = ~clk_core;

    // ---------------- reference model ----------------
    function automatic int model_word(input logic [63:0] addr, input int len, input int burst, input int beat);
        longint unsigned a, size, lower;
        a = addr + longint'(beat) * 64;
        if (burst == 0) a = addr;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            size  = longint'(len + 1) * 64;
            lower = (addr / size) * size;
            a     = lower + ((addr - lower) + longint'(beat) * 64) % size;
        end
        return int'((a / 64) % 4096);
    endfunction

    function automatic logic [1:0] model_resp(input logic [63:0] addr);
        return (addr >= 64'h400 && addr <= 64'h410) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- ready drivers and monitors ----------------
    always @(posedge clk_core) begin
        #1;
        axi.cl_sh_ddr_bready = (bready_mode == 2) ? 1'($urandom_range(0, 1)) : (bready_mode == 1);
        axi.cl_sh_ddr_rready = (rready_mode == 2) ? 1'($urandom_range(0, 1)) : (rready_mode == 1);
    end

    always @(negedge clk_core) begin
        if (!rst_core && axi.sh_cl_ddr_bvalid && axi.cl_sh_ddr_bready) begin
            b_exp_t e;
            checks++;
            if (exp_b_q.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected bid=%h bresp=%b", axi.sh_cl_ddr_bid, axi.sh_cl_ddr_bresp);
            end else begin
                e = exp_b_q.pop_front();
                if ({axi.sh_cl_ddr_bid, axi.sh_cl_ddr_bresp} !== e) begin
                    errors++;
                    $display("FAIL b_resp actual id=%h resp=%b expected id=%h resp=%b",
                             axi.sh_cl_ddr_bid, axi.sh_cl_ddr_bresp, e.id, e.resp);
                end
            end
        end
    end

    always @(negedge clk_core) begin
        if (!rst_core && axi.sh_cl_ddr_rvalid && axi.cl_sh_ddr_rready) begin
            r_exp_t e;
            checks++;
            if (exp_r_q.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected rid=%h", axi.sh_cl_ddr_rid);
            end else begin
                e = exp_r_q.pop_front();
                if ({axi.sh_cl_ddr_rid, axi.sh_cl_ddr_rresp, axi.sh_cl_ddr_rlast, axi.sh_cl_ddr_rdata} !== e) begin
                    errors++;
                    $display("FAIL r_beat actual id=%h resp=%b last=%b data=%h expected id=%h resp=%b last=%b data=%h",
                             axi.sh_cl_ddr_rid, axi.sh_cl_ddr_rresp, axi.sh_cl_ddr_rlast, axi.sh_cl_ddr_rdata,
                             e.id, e.resp, e.last, e.data);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        @(posedge clk_core); #1;
        exp_b_q.push_back('{id: id, resp: model_resp(addr)});
        axi.cl_sh_ddr_awid = id; axi.cl_sh_ddr_awaddr = addr;
        axi.cl_sh_ddr_awlen = len; axi.cl_sh_ddr_awburst = burst; axi.cl_sh_ddr_awvalid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk_core);
            if (axi.sh_cl_ddr_awready) begin ok = 1; break; end
        end
        if (!ok) chk("aw_handshake_timeout", 64'd0, 64'd1);
        @(posedge clk_core); #1;
        axi.cl_sh_ddr_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] addr, input int len, input int burst, input int bad_last);
        @(posedge clk_core); #1;
        for (int b = 0; b <= len; b++) begin
            bit ok = 0;
            int w;
            axi.cl_sh_ddr_wdata = wdat[b]; axi.cl_sh_ddr_wstrb = wstb[b];
            axi.cl_sh_ddr_wlast = (bad_last >= 0) ? (b == bad_last) : (b == len);
            axi.cl_sh_ddr_wvalid = 1'b1;
            for (int t = 0; t < 500; t++) begin
                @(negedge clk_core);
                if (axi.sh_cl_ddr_wready) begin ok = 1; break; end
            end
            if (!ok) chk("w_handshake_timeout", 64'd0, 64'd1);
            @(posedge clk_core); #1;
            w = model_word(addr, len, burst, b);
            for (int k = 0; k < DW/8; k++) if (wstb[b][k]) ref_mem[w][k*8 +: 8] = wdat[b][k*8 +: 8];
        end
        axi.cl_sh_ddr_wvalid = 1'b0;
        axi.cl_sh_ddr_wlast  = 1'b0;
    endtask

    task automatic write_burst(input logic [15:0] id, input logic [63:0] addr, input int len, input int burst, input int bad_last);
        send_aw(id, addr, 8'(len), 2'(burst));
        send_w(addr, len, burst, bad_last);
    endtask

    // Returns the number of clk_core edges from the AR handshake to the first visible rvalid.
    task automatic read_burst(input logic [15:0] id, input logic [63:0] addr, input int len, input int burst, output int lat);
        bit ok = 0;
        for (int b = 0; b <= len; b++)
            exp_r_q.push_back('{id: id, resp: model_resp(addr), last: (b == len),
                                data: ref_mem[model_word(addr, len, burst, b)]});
        @(posedge clk_core); #1;
        axi.cl_sh_ddr_arid = id; axi.cl_sh_ddr_araddr = addr;
        axi.cl_sh_ddr_arlen = 8'(len); axi.cl_sh_ddr_arburst = 2'(burst); axi.cl_sh_ddr_arvalid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk_core);
            if (axi.sh_cl_ddr_arready) begin ok = 1; break; end
        end
        if (!ok) chk("ar_handshake_timeout", 64'd0, 64'd1);
        @(posedge clk_core); #1;
        axi.cl_sh_ddr_arvalid = 1'b0;
        lat = 0;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk_core);
            if (axi.sh_cl_ddr_rvalid) begin ok = 1; break; end
            @(posedge clk_core);
            lat++;
        end
        if (!ok) chk("rvalid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk_core);
            if (exp_b_q.size() == 0 && exp_r_q.size() == 0) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout pending_b=%0d pending_r=%0d expected 0/0", exp_b_q.size(), exp_r_q.size());
            exp_b_q.delete(); exp_r_q.delete();
        end
        repeat (2) @(negedge clk_core);
    endtask

    task automatic fill(input int n, input bit full_strb);
        for (int b = 0; b < n; b++) begin
            wdat[b] = rand_data();
            wstb[b] = full_strb ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int lens [7] = '{0, 1, 3, 7, 15, 2, 5};
        axi.cl_sh_ddr_awvalid = 1'b0; axi.cl_sh_ddr_wvalid = 1'b0; axi.cl_sh_ddr_arvalid = 1'b0;
        axi.cl_sh_ddr_awid = '0; axi.cl_sh_ddr_awaddr = '0; axi.cl_sh_ddr_awlen = '0; axi.cl_sh_ddr_awburst = '0;
        axi.cl_sh_ddr_wdata = '0; axi.cl_sh_ddr_wstrb = '0; axi.cl_sh_ddr_wlast = 1'b0;
        axi.cl_sh_ddr_arid = '0; axi.cl_sh_ddr_araddr = '0; axi.cl_sh_ddr_arlen = '0; axi.cl_sh_ddr_arburst = '0;

        repeat (3) @(posedge clk_core);
        #2;
        chk("rst_awready", 64'(axi.sh_cl_ddr_awready), 64'd0);
        chk("rst_arready", 64'(axi.sh_cl_ddr_arready), 64'd0);
        chk("rst_wready", 64'(axi.sh_cl_ddr_wready), 64'd0);
        chk("rst_bvalid", 64'(axi.sh_cl_ddr_bvalid), 64'd0);
        chk("rst_rvalid", 64'(axi.sh_cl_ddr_rvalid), 64'd0);
        chk("rst_bid_bresp", 64'({axi.sh_cl_ddr_bid, axi.sh_cl_ddr_bresp}), 64'd0);
        chk("rst_rid_rresp_rlast", 64'({axi.sh_cl_ddr_rid, axi.sh_cl_ddr_rresp, axi.sh_cl_ddr_rlast}), 64'd0);
        chk("rst_rdata", axi.sh_cl_ddr_rdata[63:0], 64'd0);
        chk("rst_protocol_err", 64'(protocol_err), 64'd0);
        chk("rst_rd_idle", 64'(dbg_rd_state), 64'd0);
        @(negedge clk_core);
        rst_core = 1'b0;
        #1 chk("awready_before_first_edge", 64'(axi.sh_cl_ddr_awready), 64'd0);
        @(negedge clk_core);
        chk("awready_after_rst", 64'(axi.sh_cl_ddr_awready), 64'd1);
        chk("arready_after_rst", 64'(axi.sh_cl_ddr_arready), 64'd1);

        // INCR write/read with latency measurement
        for (int b = 0; b < 4; b++) begin wdat[b] = DW'(8'hA0 + b); wstb[b] = '1; end
        write_burst(16'h0001, 64'h0, 3, 1, -1);
        wait_drain();
        read_burst(16'h0002, 64'h0, 3, 1, lat);
        chk("first_rvalid_latency", 64'(lat), 64'(RD_LAT + 1));
        wait_drain();

        // WRAP from word 2 lands on 2,3,0,1
        for (int b = 0; b < 4; b++) begin wdat[b] = DW'(8'hB0 + b); wstb[b] = '1; end
        write_burst(16'h0003, 64'h80, 3, 2, -1);
        wait_drain();
        chk("wrap_word0", ref_mem[0][63:0], 64'hB2);
        chk("wrap_word2", ref_mem[2][63:0], 64'hB0);
        read_burst(16'h0004, 64'h0, 3, 1, lat);
        wait_drain();

        // Partial strobe over an all-ones word
        wdat[0] = '1; wstb[0] = '1;
        write_burst(16'h0005, 64'h100, 0, 1, -1);
        wdat[0] = DW'(8'h11); wstb[0] = 64'h1;
        write_burst(16'h0006, 64'h100, 0, 1, -1);
        wait_drain();
        read_burst(16'h0007, 64'h100, 0, 1, lat);
        wait_drain();

        // Error window and just outside it
        fill(2, 1'b1);
        write_burst(16'h0008, 64'h400, 1, 1, -1);
        fill(2, 1'b1);
        write_burst(16'h0009, 64'h440, 1, 1, -1);
        wait_drain();
        read_burst(16'h000A, 64'h400, 1, 1, lat);
        read_burst(16'h000B, 64'h440, 1, 1, lat);
        wait_drain();

        // Backpressure: AW queue fills, then B queue blocks W
        bready_mode = 0;
        repeat (2) @(negedge clk_core);
        aw_sent = 0;
        fork
            for (int i = 0; i < 5; i++) begin
                send_aw(16'h0050 + 16'(i), 64'((200 + i) * 64), 8'd0, 2'b01);
                aw_sent++;
            end
        join_none
        for (int t = 0; t < 200 && aw_sent < 4; t++) @(negedge clk_core);
        @(negedge clk_core);
        chk("aw_accepted_before_full", 64'(aw_sent), 64'd4);
        chk("awready_full", 64'(axi.sh_cl_ddr_awready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            fill(1, 1'b1);
            send_w(64'((200 + i) * 64), 0, 1, -1);
        end
        repeat (3) @(negedge clk_core);
        chk("fifth_aw_accepted", 64'(aw_sent), 64'd5);
        chk("wready_b_full", 64'(axi.sh_cl_ddr_wready), 64'd0);
        chk("bvalid_held", 64'(axi.sh_cl_ddr_bvalid), 64'd1);
        bready_mode = 1;
        fill(1, 1'b1);
        send_w(64'(204 * 64), 0, 1, -1);
        wait_drain();

        // Initialise words 0..127, then randomized traffic with random ready stalls
        for (int k = 0; k < 8; k++) begin
            fill(16, 1'b1);
            write_burst(16'(16'h0100 + k), 64'(k * 16 * 64), 15, 1, -1);
        end
        wait_drain();
        bready_mode = 2; rready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            logic [63:0] addr;
            int len, burst;
            addr  = 64'($urandom_range(0, 112) * 64 + $urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) addr = addr + 64'h40000;
            len   = lens[$urandom_range(0, 6)];
            burst = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                fill(len + 1, 1'b0);
                write_burst(16'($urandom), addr, len, burst, -1);
            end else begin
                read_burst(16'($urandom), addr, len, burst, lat);
            end
            wait_drain();
        end

        // Sticky wlast mismatch
        bready_mode = 1; rready_mode = 1;
        chk("protocol_err_clean", 64'(protocol_err), 64'd0);
        fill(4, 1'b1);
        write_burst(16'h0200, 64'(300 * 64), 3, 1, 1);
        wait_drain();
        chk("protocol_err_set", 64'(protocol_err), 64'd1);
        fill(2, 1'b1);
        write_burst(16'h0201, 64'(310 * 64), 1, 1, -1);
        wait_drain();
        chk("protocol_err_sticky", 64'(protocol_err), 64'd1);

        // Reset in the middle of a stalled read burst
        rready_mode = 0;
        repeat (2) @(negedge clk_core);
        read_burst(16'h0300, 64'h0, 15, 1, lat);
        @(posedge clk_core); #3;
        rst_core = 1'b1;
        #1;
        chk("rvalid_async_rst", 64'(axi.sh_cl_ddr_rvalid), 64'd0);
        chk("protocol_err_rst", 64'(protocol_err), 64'd0);
        exp_r_q.delete(); exp_b_q.delete();
        repeat (2) @(negedge clk_core);
        rst_core = 1'b0;
        rready_mode = 2;
        read_burst(16'h0301, 64'h0, 3, 1, lat);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
